toggle_event_sync: RTL and testbench

TOGGLE_EVENT_SYNC -- requirements
Module: toggle_event_sync

---
 rtl/toggle_event_sync.sv | 118 +++++++++++
 tb/tb_toggle_event_sync.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_sync.sv
// Multi-channel toggle-event synchronizer: per-channel sync chain and edge detect,
// saturating pending counters, round-robin valid/ready event presentation.
module toggle_event_sync #(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 4,
    localparam int CHW        = ($clog2(NCH) > 1) ? $clog2(NCH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NCH-1:0]   i_toggle,
    output logic [NCH-1:0]   o_pulse,
    output logic             o_valid,
    output logic [CHW-1:0]   o_chan,
    input  logic             i_ready,
    output logic [NCH-1:0]   o_overflow,
    input  logic             i_clr_ovf
);

    localparam int             MW      = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
    localparam logic [CHW:0]   NCH_W   = (CHW + 1)'(NCH);

    logic [SYNC_STAGES-1:0][NCH-1:0] r_sync;
    logic [MW-1:0]                   r_mask_cnt;
    logic [NCH-1:0][CNT_W-1:0]       r_cnt;
    logic [NCH-1:0]                  r_ovf;
    logic                            r_valid;
    logic [CHW-1:0]                  r_chan;
    logic [CHW-1:0]                  r_ptr;

    logic [NCH-1:0][CNT_W-1:0]       w_cnt_next;
    logic [NCH-1:0]                  w_ovf_set;
    logic [NCH-1:0]                  w_pulse;
    logic [NCH-1:0]                  w_dec;
    logic                            w_mask;
    logic                            w_accept;
    logic                            w_load;
    logic                            w_sel_vld;
    logic [CHW-1:0]                  w_sel_chan;
    logic [CHW-1:0]                  w_start;
    logic [CHW:0]                    w_sum;

    // Mask stays up until the chains have refilled with post-reset samples.
    assign w_mask   = (r_mask_cnt != MW'(SYNC_STAGES));
    assign w_pulse  = (r_sync[SYNC_STAGES-1] ^ r_sync[SYNC_STAGES-2]) & {NCH{~w_mask}};
    assign w_accept = r_valid & i_ready;
    assign w_load   = ~r_valid | w_accept;
    assign w_start  = w_accept ? ((r_chan == LAST_CH) ? '0 : r_chan + CHW'(1)) : r_ptr;

    always_comb begin
        w_cnt_next = r_cnt;
        w_ovf_set  = '0;
        w_dec      = '0;
        for (int c = 0; c < NCH; c++) begin
            w_dec[c] = w_accept && (r_chan == CHW'(c));
            if (w_pulse[c] && !w_dec[c]) begin
                if (r_cnt[c] == CNT_MAX) begin
                    w_ovf_set[c] = 1'b1;
                end else begin
                    w_cnt_next[c] = r_cnt[c] + CNT_W'(1);
                end
            end else if (w_dec[c] && !w_pulse[c]) begin
                w_cnt_next[c] = r_cnt[c] - CNT_W'(1);
            end
        end
    end

    // Round-robin pick over post-update counts, starting after the last accepted channel.
    always_comb begin
        w_sel_vld  = 1'b0;
        w_sel_chan = '0;
        w_sum      = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = {1'b0, w_start} + (CHW + 1)'(i);
            if (w_sum >= NCH_W) begin
                w_sum = w_sum - NCH_W;
            end
            if (!w_sel_vld && (w_cnt_next[w_sum[CHW-1:0]] != '0)) begin
                w_sel_vld  = 1'b1;
                w_sel_chan = w_sum[CHW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync     <= '0;
            r_mask_cnt <= '0;
            r_cnt      <= '0;
            r_ovf      <= '0;
            r_valid    <= 1'b0;
            r_chan     <= '0;
            r_ptr      <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
            if (w_mask) begin
                r_mask_cnt <= r_mask_cnt + MW'(1);
            end
            r_cnt <= w_cnt_next;
            r_ovf <= (r_ovf & ~{NCH{i_clr_ovf}}) | w_ovf_set;
            if (w_accept) begin
                r_ptr <= w_start;
            end
            if (w_load) begin
                r_valid <= w_sel_vld;
                r_chan  <= w_sel_chan;
            end
        end
    end

    assign o_pulse    = w_pulse;
    assign o_valid    = r_valid;
    assign o_chan     = r_chan;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_toggle_event_sync.sv
// Directed bench for toggle_event_sync: event-level reference model compared every
// cycle, plus hand-computed expectations for each scenario.
module tb_toggle_event_sync;

    localparam int NCH  = 4;
    localparam int S    = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] i_toggle;
    logic           i_ready;
    logic           i_clr_ovf;
    logic [NCH-1:0] o_pulse;
    logic           o_valid;
    logic [1:0]     o_chan;
    logic [NCH-1:0] o_overflow;

    int n_checks = 0;
    int n_err    = 0;

    toggle_event_sync #(.NCH(NCH), .SYNC_STAGES(S), .CNT_W(CW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_toggle   (i_toggle),
        .o_pulse    (o_pulse),
        .o_valid    (o_valid),
        .o_chan     (o_chan),
        .i_ready    (i_ready),
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: events are level changes of the sampled input, seen S-2 edges later.
    int             m_cnt [NCH];
    logic [NCH-1:0] m_pulse = '0;
    logic [NCH-1:0] m_ovf   = '0;
    logic           m_valid = 1'b0;
    int             m_chan  = 0;
    int             m_start = 0;
    int             m_edges = 0;
    logic [NCH-1:0] m_samp [$];

    function automatic logic [NCH-1:0] samp_at(input int k);
        if (k < 1 || k > m_samp.size()) return '0;
        return m_samp[k-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_cnt[c]) m_cnt[c] = 0;
            m_pulse = '0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_chan  = 0;
            m_start = 0;
            m_edges = 0;
            m_samp.delete();
        end else begin
            logic           acc;
            logic [NCH-1:0] set;
            acc = m_valid && i_ready;
            set = '0;
            for (int c = 0; c < NCH; c++) begin
                logic inc, dec;
                inc = m_pulse[c];
                dec = acc && (m_chan == c);
                if (inc && !dec) begin
                    if (m_cnt[c] == CMAX) set[c] = 1'b1;
                    else m_cnt[c]++;
                end else if (dec && !inc) begin
                    m_cnt[c]--;
                end
            end
            m_ovf = (i_clr_ovf ? '0 : m_ovf) | set;
            if (!m_valid || acc) begin
                if (acc) m_start = (m_chan + 1) % NCH;
                m_valid = 1'b0;
                for (int i = 0; i < NCH; i++) begin
                    int c;
                    c = (m_start + i) % NCH;
                    if (!m_valid && m_cnt[c] > 0) begin
                        m_valid = 1'b1;
                        m_chan  = c;
                    end
                end
            end
            m_samp.push_back(i_toggle);
            m_edges++;
            m_pulse = (m_edges >= S) ? (samp_at(m_edges - S + 2) ^ samp_at(m_edges - S + 1)) : '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_pulse", o_pulse, m_pulse);
            check("model_valid", o_valid, m_valid);
            if (m_valid) check("model_chan", o_chan, m_chan);
            check("model_ovf", o_overflow, m_ovf);
        end
    end

    initial begin
        int n_acc;
        rst       = 1'b0;
        i_toggle  = 4'b0101;
        i_ready   = 1'b0;
        i_clr_ovf = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_chan", o_chan, 0);
        check("rst_pulse", o_pulse, 0);
        check("rst_ovf", o_overflow, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Static nonzero level across reset must not produce events.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("static_pulse", o_pulse, 0);
            check("static_valid", o_valid, 0);
        end
        check("static_ovf", o_overflow, 0);

        // Single toggle on ch2: pulse two cycles later, presented one cycle after that.
        i_ready  = 1'b1;
        i_toggle = i_toggle ^ 4'b0100;
        @(negedge clk);
        check("ch2_pulse_early", o_pulse, 0);
        @(negedge clk);
        check("ch2_pulse", o_pulse, 4'b0100);
        check("ch2_model_pulse", m_pulse, 4'b0100);
        check("ch2_valid_early", o_valid, 0);
        @(negedge clk);
        check("ch2_pulse_gone", o_pulse, 0);
        check("ch2_valid", o_valid, 1);
        check("ch2_chan", o_chan, 2);
        check("ch2_model_chan", m_chan, 2);
        @(negedge clk);
        check("ch2_drained", o_valid, 0);

        // Simultaneous toggles on 0,1,3 from pointer 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        i_toggle = i_toggle ^ 4'b1011;
        repeat (2) @(negedge clk);
        check("multi_pulse", o_pulse, 4'b1011);
        @(negedge clk);
        check("multi_v0", o_valid, 1);
        check("multi_c0", o_chan, 0);
        @(negedge clk);
        check("multi_v1", o_valid, 1);
        check("multi_c1", o_chan, 1);
        @(negedge clk);
        check("multi_v3", o_valid, 1);
        check("multi_c3", o_chan, 3);
        @(negedge clk);
        check("multi_done", o_valid, 0);

        // Saturation: 16 events on ch1 with no consumer.
        i_ready = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            i_toggle = i_toggle ^ 4'b0010;
            repeat (4) @(negedge clk);
            if (k == 15) check("sat_ovf_before", o_overflow, 0);
        end
        check("sat_ovf", o_overflow, 4'b0010);
        check("sat_valid", o_valid, 1);
        check("sat_chan", o_chan, 1);
        check("sat_model_cnt", m_cnt[1], 15);
        n_acc = 0;
        for (int i = 0; i < 40; i++) begin
            i_ready = 1'b1;
            if (o_valid && o_chan == 2'd1) n_acc++;
            @(negedge clk);
        end
        check("sat_accepts", n_acc, 15);
        check("sat_empty", o_valid, 0);
        check("sat_ovf_sticky", o_overflow, 4'b0010);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        check("ovf_cleared", o_overflow, 0);

        // Pulse coincident with accept of the only pending event.
        i_ready  = 1'b0;
        i_toggle = i_toggle ^ 4'b0010;
        repeat (3) @(negedge clk);
        check("coin_v_pre", o_valid, 1);
        check("coin_c_pre", o_chan, 1);
        i_toggle = i_toggle ^ 4'b0010;
        repeat (2) @(negedge clk);
        check("coin_pulse", o_pulse, 4'b0010);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("coin_valid", o_valid, 1);
        check("coin_chan", o_chan, 1);
        @(negedge clk);
        check("coin_hold_v", o_valid, 1);
        check("coin_hold_c", o_chan, 1);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("coin_drain", o_valid, 0);

        // Reset mid-cycle with three events pending.
        i_toggle = i_toggle ^ 4'b1101;
        repeat (4) @(negedge clk);
        check("mid_valid_pre", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", o_valid, 0);
        check("mid_chan", o_chan, 0);
        check("mid_ovf", o_overflow, 0);
        check("mid_pulse", o_pulse, 0);
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_rst_valid", o_valid, 0);
            check("post_rst_pulse", o_pulse, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
